// File: rtl/conv_pkg.sv
// Shared types and constants for the conv input-fetch row-segment generator.
// Optional multi-row iteration is enabled by defining CONV_SEG_ROW_LOOP_EN.
package conv_pkg;
   localparam int CONV_AW            = 16;
   localparam int CONV_KW            = 4;
   localparam int CONV_PIXELS_IN_ROW = 32;
   localparam int CONV_PIX_LOG2      = $clog2(CONV_PIXELS_IN_ROW);

   typedef enum logic [1:0] {IDLE, CALC, EMIT} seg_state_t;

   typedef struct packed {
      logic [CONV_AW-1:0] row;
      logic [CONV_AW-1:0] col_start;
      logic [CONV_AW-1:0] col_end;
      logic               empty;
      logic [CONV_KW-1:0] west_pad;
      logic [CONV_KW-1:0] east_pad;
      logic [CONV_AW-1:0] reg_start;
      logic [CONV_AW-1:0] reg_end;
      logic               last_row;
      logic               last;
   } seg_desc_t;
endpackage

// File: rtl/conv_row_window_calc.sv
// Combinational derivation of the padded input window for one output-column tile:
// window bounds, west/east pad counts and the clipped in-buffer column range.
module conv_row_window_calc #(
   parameter int AW = 16,
   parameter int KW = 4
) (
   input  logic [AW-1:0] ix,
   input  logic [AW-1:0] ox_start,
   input  logic [AW-1:0] pox,
   input  logic [KW-1:0] k,
   input  logic [KW-1:0] s,
   input  logic [KW-1:0] p,
   output logic [KW-1:0] left_pad,
   output logic [KW-1:0] right_pad,
   output logic [AW-1:0] row_lo,
   output logic [AW-1:0] row_hi,
   output logic          empty
);
   logic [AW-1:0] s_w, k_w, p_w;
   logic [AW-1:0] ix_start, ix_end, data_end, hi_cand;

   assign s_w = AW'(s);
   assign k_w = AW'(k);
   assign p_w = AW'(p);

   // 1-based coordinates in the padded row; data occupies p+1 .. p+ix
   assign ix_start = (ox_start - AW'(1)) * s_w + AW'(1);
   assign ix_end   = ix_start + (pox - AW'(1)) * s_w + k_w - AW'(1);
   assign data_end = p_w + ix;

   // Pads never exceed KW bits, so only the low bits of the operands matter
   assign left_pad  = (ix_start <= p_w) ? p - ix_start[KW-1:0] + KW'(1) : '0;
   assign right_pad = (ix_end > data_end) ? ix_end[KW-1:0] - p - ix[KW-1:0] : '0;

   assign empty   = (ix_end <= p_w) || (ix_start > data_end);
   assign row_lo  = (ix_start > p_w + AW'(1)) ? ix_start - p_w - AW'(1) : '0;
   assign hi_cand = ix_end - p_w - AW'(1);
   assign row_hi  = (hi_cand < ix) ? hi_cand : ix - AW'(1);
endmodule

// File: rtl/conv_row_seg_gen.sv
// Splits one padded input-row window into fetch segments of at most PIXELS_IN_ROW
// pixels; define CONV_SEG_ROW_LOOP_EN to repeat the segmentation over k rows.
module conv_row_seg_gen
   import conv_pkg::*;
#(
   parameter int PIXELS_IN_ROW = CONV_PIXELS_IN_ROW,
   parameter int AW            = CONV_AW,
   parameter int KW            = CONV_KW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic [AW-1:0] row_y,
   input  logic [AW-1:0] ix,
   input  logic [AW-1:0] ox_start,
   input  logic [AW-1:0] pox,
   input  logic [KW-1:0] k,
   input  logic [KW-1:0] s,
   input  logic [KW-1:0] p,
   output logic          busy,
   output logic          seg_valid,
   input  logic          seg_ready,
   output logic [AW-1:0] seg_row,
   output logic [AW-1:0] seg_start,
   output logic [AW-1:0] seg_end,
   output logic          seg_empty,
   output logic [KW-1:0] west_pad,
   output logic [KW-1:0] east_pad,
   output logic [AW-1:0] reg_start,
   output logic [AW-1:0] reg_end,
   output logic          seg_last_row,
   output logic          seg_last,
   output logic          done
);
   seg_state_t    state, state_n;
   logic [AW-1:0] in_row, in_ix, in_ox, in_pox;
   logic [KW-1:0] in_k, in_s, in_p;
   logic [AW-1:0] win_lo, win_hi, lo_r, hi_r;
   logic [KW-1:0] win_lp, win_rp, lp_r, rp_r;
   logic          win_empty, empty_r;
   logic [AW-1:0] cur_start, cur_reg, end_cand, seg_end_c, reg_end_c, row_c;
   logic          row_done, cmd_done, hs;
   seg_desc_t     desc;

   conv_row_window_calc #(.AW(AW), .KW(KW)) u_calc (
      .ix(in_ix), .ox_start(in_ox), .pox(in_pox), .k(in_k), .s(in_s), .p(in_p),
      .left_pad(win_lp), .right_pad(win_rp), .row_lo(win_lo), .row_hi(win_hi),
      .empty(win_empty)
   );

`ifdef CONV_SEG_ROW_LOOP_EN
   logic [KW-1:0] row_off;
   assign row_c    = in_row + AW'(row_off);
   assign cmd_done = row_done && (row_off == in_k - KW'(1));
`else
   assign row_c    = in_row;
   assign cmd_done = row_done;
`endif

   assign end_cand  = cur_start + AW'(PIXELS_IN_ROW - 1);
   assign seg_end_c = (end_cand < hi_r) ? end_cand : hi_r;
   assign row_done  = empty_r || (end_cand >= hi_r);
   // An empty row still reports its west pads as slots 0 .. left_pad-1
   assign reg_end_c = empty_r ? AW'(lp_r) - AW'(1) : cur_reg + seg_end_c - cur_start;
   assign hs        = (state == EMIT) && seg_ready;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (start) state_n = CALC;
         CALC:    state_n = EMIT;
         EMIT:    if (hs && cmd_done) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         in_row <= '0; in_ix <= '0; in_ox <= '0; in_pox <= '0;
         in_k <= '0; in_s <= '0; in_p <= '0;
         lo_r <= '0; hi_r <= '0; lp_r <= '0; rp_r <= '0; empty_r <= 1'b0;
         cur_start <= '0; cur_reg <= '0;
`ifdef CONV_SEG_ROW_LOOP_EN
         row_off <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (start) begin
               in_row <= row_y; in_ix <= ix; in_ox <= ox_start; in_pox <= pox;
               in_k <= k; in_s <= s; in_p <= p;
            end
            CALC: begin
               lo_r <= win_lo; hi_r <= win_hi; lp_r <= win_lp; rp_r <= win_rp;
               empty_r   <= win_empty;
               cur_start <= win_lo;
               cur_reg   <= AW'(win_lp);
`ifdef CONV_SEG_ROW_LOOP_EN
               row_off <= '0;
`endif
            end
            EMIT: if (hs) begin
               if (row_done) begin
                  cur_start <= lo_r;
                  cur_reg   <= AW'(lp_r);
`ifdef CONV_SEG_ROW_LOOP_EN
                  row_off <= row_off + KW'(1);
`endif
               end else begin
                  cur_start <= cur_start + AW'(PIXELS_IN_ROW);
                  cur_reg   <= reg_end_c + AW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      desc = '0;
      if (state == EMIT) begin
         desc.row       = row_c;
         desc.col_start = empty_r ? '0 : cur_start;
         desc.col_end   = empty_r ? '0 : seg_end_c;
         desc.empty     = empty_r;
         desc.west_pad  = (empty_r || cur_start == lo_r) ? lp_r : '0;
         desc.east_pad  = row_done ? rp_r : '0;
         desc.reg_start = empty_r ? '0 : cur_reg;
         desc.reg_end   = reg_end_c;
         desc.last_row  = row_done;
         desc.last      = cmd_done;
      end
   end

   assign busy         = (state != IDLE);
   assign seg_valid    = (state == EMIT);
   assign done         = hs && cmd_done;
   assign seg_row      = desc.row;
   assign seg_start    = desc.col_start;
   assign seg_end      = desc.col_end;
   assign seg_empty    = desc.empty;
   assign west_pad     = desc.west_pad;
   assign east_pad     = desc.east_pad;
   assign reg_start    = desc.reg_start;
   assign reg_end      = desc.reg_end;
   assign seg_last_row = desc.last_row;
   assign seg_last     = desc.last;
endmodule
